pi_bus_sequencer: RTL and testbench

Executes single-byte memory transactions requested by the Pi command decoder on the shared RAM/IO bus. It sits directly downstream of the decoder: it consumes the decoder's address, write data, read/write flag and pending flag; waits for a Pi bus slot from the timing generator; drives the RAM strobes; and returns read data and a done flag to the decoder.

---
 rtl/pi_bus_sequencer_pkg.sv | 32 +++
 rtl/pi_bus_sequencer_if.sv | 36 +++
 rtl/pi_bus_sequencer_timer.sv | 30 +++
 rtl/pi_bus_sequencer.sv | 178 +++++++++++++++++
 tb/tb_pi_bus_sequencer.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pi_bus_sequencer_pkg.sv
// pi_bus_pkg: shared types and constants for the Pi bus sequencer.
package pi_bus_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned ADDR_W  = 17;
  localparam int unsigned DATA_W  = 8;

  localparam int unsigned DEF_SETUP_CYCLES   = 1;
  localparam int unsigned DEF_STROBE_CYCLES  = 2;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 255;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_SLOT = 3'd1,
    ST_SETUP     = 3'd2,
    ST_STROBE    = 3'd3,
    ST_HOLD      = 3'd4,
    ST_DONE      = 3'd5
  } pi_state_e;

  // Request captured from the decoder when a transaction is accepted.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              rd;
  } pi_req_t;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pi_bus_sequencer_if.sv
// Decoder handshake and RAM/IO bus signals of the Pi bus sequencer.
interface pi_bus_sequencer_if;
  import pi_bus_pkg::*;

  // decoder side
  logic [ADDR_W-1:0] pi_addr;
  logic [DATA_W-1:0] pi_wr_data;
  logic              pi_rw_b;
  logic              pi_pending;
  logic [DATA_W-1:0] pi_rd_data;
  logic              pi_done;
  logic              pi_error;
  // bus side
  logic              bus_slot;
  logic [DATA_W-1:0] bus_data_in;
  logic              bus_own;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_data_out;
  logic              bus_data_oe;
  logic              ram_we_n;
  logic              ram_oe_n;

  // sequencer view
  modport slave (
    input  pi_addr, pi_wr_data, pi_rw_b, pi_pending, bus_slot, bus_data_in,
    output pi_rd_data, pi_done, pi_error, bus_own, bus_addr, bus_data_out,
           bus_data_oe, ram_we_n, ram_oe_n
  );

  // decoder / timing generator / RAM view
  modport master (
    output pi_addr, pi_wr_data, pi_rw_b, pi_pending, bus_slot, bus_data_in,
    input  pi_rd_data, pi_done, pi_error, bus_own, bus_addr, bus_data_out,
           bus_data_oe, ram_we_n, ram_oe_n
  );
endinterface

// File: rtl/pi_bus_sequencer_timer.sv
// pi_bus_timer: loadable down-counter that stops at zero and flags it.
module pi_bus_timer #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_d, cnt_q;

  // load wins over decrement; saturate at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load)                   cnt_d = load_val;
    else if (dec && cnt_q != '0) cnt_d = cnt_q - 1'b1;
  end

  // counter register
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/pi_bus_sequencer.sv
// pi_bus_sequencer: runs one single-byte RAM/IO access per decoder request
// inside a Pi bus slot. Optional WAIT_SLOT timeout under PI_BUS_TIMEOUT_EN.
module pi_bus_sequencer
  import pi_bus_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES   = DEF_SETUP_CYCLES,
  parameter int unsigned STROBE_CYCLES  = DEF_STROBE_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic               sys_clk,
  input  logic               reset_n,
  pi_bus_sequencer_if.slave  bus,
  output logic [STATE_W-1:0] state
);

  localparam int unsigned PH_W = $clog2(max2(SETUP_CYCLES, STROBE_CYCLES) + 1);
  localparam logic [PH_W-1:0] SETUP_LD  = PH_W'(SETUP_CYCLES - 1);
  localparam logic [PH_W-1:0] STROBE_LD = PH_W'(STROBE_CYCLES - 1);

  pi_state_e         state_q;
  pi_req_t           req_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              done_q;
  logic              own_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [DATA_W-1:0] dout_q;
  logic              doe_q;
  logic              we_n_q;
  logic              oe_n_q;

  logic              ph_load;
  logic [PH_W-1:0]   ph_val;
  logic              ph_dec;
  logic              ph_zero;

  // phase counter control, kept in step with the FSM transitions
  always_comb begin
    ph_load = 1'b0;
    ph_val  = '0;
    ph_dec  = 1'b0;
    case (state_q)
      ST_WAIT_SLOT: if (bus.bus_slot) begin
        ph_load = 1'b1;
        ph_val  = SETUP_LD;
      end
      ST_SETUP: if (ph_zero) begin
        ph_load = 1'b1;
        ph_val  = STROBE_LD;
      end else begin
        ph_dec  = 1'b1;
      end
      ST_STROBE: ph_dec = 1'b1;
      default: ;
    endcase
  end

  pi_bus_timer #(.W(PH_W)) u_phase (
    .clk      (sys_clk),
    .rst_n    (reset_n),
    .load     (ph_load),
    .load_val (ph_val),
    .dec      (ph_dec),
    .zero     (ph_zero)
  );

`ifdef PI_BUS_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LD = TO_W'(TIMEOUT_CYCLES - 1);

  logic to_load;
  logic to_dec;
  logic to_zero;
  logic err_q;

  // rearm on every entry to WAIT_SLOT, count only while waiting
  always_comb begin
    to_load = (state_q == ST_IDLE) && bus.pi_pending;
    to_dec  = (state_q == ST_WAIT_SLOT);
  end

  pi_bus_timer #(.W(TO_W)) u_timeout (
    .clk      (sys_clk),
    .rst_n    (reset_n),
    .load     (to_load),
    .load_val (TO_LD),
    .dec      (to_dec),
    .zero     (to_zero)
  );
`endif

  // transaction FSM with registered bus and handshake outputs
  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      req_q      <= '0;
      rd_data_q  <= '0;
      done_q     <= 1'b0;
      own_q      <= 1'b0;
      bus_addr_q <= '0;
      dout_q     <= '0;
      doe_q      <= 1'b0;
      we_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
`ifdef PI_BUS_TIMEOUT_EN
      err_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: if (bus.pi_pending) begin
          req_q   <= '{addr: bus.pi_addr, data: bus.pi_wr_data, rd: bus.pi_rw_b};
          state_q <= ST_WAIT_SLOT;
        end
        ST_WAIT_SLOT: begin
          if (bus.bus_slot) begin
            state_q    <= ST_SETUP;
            own_q      <= 1'b1;
            bus_addr_q <= req_q.addr;
            if (!req_q.rd) begin
              dout_q <= req_q.data;
              doe_q  <= 1'b1;
            end
          end else if (!bus.pi_pending) begin
            state_q <= ST_IDLE;
`ifdef PI_BUS_TIMEOUT_EN
          end else if (to_zero) begin
            // give up without touching the bus
            state_q   <= ST_DONE;
            done_q    <= 1'b1;
            err_q     <= 1'b1;
            rd_data_q <= 8'hFF;
`endif
          end
        end
        ST_SETUP: if (ph_zero) begin
          state_q <= ST_STROBE;
          if (req_q.rd) oe_n_q <= 1'b0;
          else          we_n_q <= 1'b0;
        end
        ST_STROBE: if (ph_zero) begin
          state_q <= ST_HOLD;
          we_n_q  <= 1'b1;
          oe_n_q  <= 1'b1;
          if (req_q.rd) rd_data_q <= bus.bus_data_in;
        end
        ST_HOLD: begin
          state_q <= ST_DONE;
          own_q   <= 1'b0;
          doe_q   <= 1'b0;
          done_q  <= 1'b1;
        end
        ST_DONE: if (!bus.pi_pending) begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
`ifdef PI_BUS_TIMEOUT_EN
          err_q   <= 1'b0;
`endif
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign state            = state_q;
  assign bus.pi_rd_data   = rd_data_q;
  assign bus.pi_done      = done_q;
  assign bus.bus_own      = own_q;
  assign bus.bus_addr     = bus_addr_q;
  assign bus.bus_data_out = dout_q;
  assign bus.bus_data_oe  = doe_q;
  assign bus.ram_we_n     = we_n_q;
  assign bus.ram_oe_n     = oe_n_q;
`ifdef PI_BUS_TIMEOUT_EN
  assign bus.pi_error     = err_q;
`else
  assign bus.pi_error     = 1'b0;
`endif

endmodule

// File: tb/tb_pi_bus_sequencer.sv
// Testbench for pi_bus_sequencer: directed and randomized transactions
// against a RAM model and a reference memory/read-data model.
module tb_pi_bus_sequencer;
  import pi_bus_pkg::*;

  localparam int S  = 1;
  localparam int T  = 2;
  localparam int TO = 8;

  logic         sys_clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [2:0]   state;

  pi_bus_sequencer_if bif();

  pi_bus_sequencer #(
    .SETUP_CYCLES   (S),
    .STROBE_CYCLES  (T),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .sys_clk (sys_clk),
    .reset_n (reset_n),
    .bus     (bif),
    .state   (state)
  );

  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] ram     [bit [16:0]];  // RAM/IO device behind the bus
  logic [7:0] ref_mem [bit [16:0]];  // what the RAM should hold
  logic [7:0] exp_rd;                // expected pi_rd_data

  function automatic logic [7:0] init_val(input logic [16:0] a);
    return 8'(a ^ (a >> 8) ^ (a >> 9) ^ 17'h0005A);
  endfunction

  function automatic logic [7:0] ref_read(input logic [16:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  // RAM model: write while the strobe is low, present read data
  always @(negedge sys_clk) begin
    if (bif.ram_we_n === 1'b0) ram[bif.bus_addr] = bif.bus_data_out;
    bif.bus_data_in = ram.exists(bif.bus_addr) ? ram[bif.bus_addr] : init_val(bif.bus_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge sys_clk);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_own"},  bif.bus_own,     0);
    chk({tag, "_doe"},  bif.bus_data_oe, 0);
    chk({tag, "_we"},   bif.ram_we_n,    1);
    chk({tag, "_oe"},   bif.ram_oe_n,    1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_state"}, state,            0);
    chk({tag, "_done"},  bif.pi_done,      0);
    chk({tag, "_err"},   bif.pi_error,     0);
    chk({tag, "_rd"},    bif.pi_rd_data,   0);
    chk({tag, "_addr"},  bif.bus_addr,     0);
    chk({tag, "_dout"},  bif.bus_data_out, 0);
    chk_quiet(tag);
  endtask

  // One full transaction; drop_at = cycle after slot where pending falls (-1: held)
  task automatic do_txn(input bit rd, input logic [16:0] a, input logic [7:0] d,
                        input int dly, input int drop_at, input bit slot_early);
    int n, oe_lo, we_lo;
    bif.pi_addr = a; bif.pi_wr_data = d; bif.pi_rw_b = rd;
    bif.pi_pending = 1'b1; bif.bus_slot = slot_early;
    tick();
    bif.bus_slot = 1'b0;
    chk("req_wait", state, 1);
    // change decoder inputs to prove they were captured
    bif.pi_addr = 17'($urandom); bif.pi_wr_data = 8'($urandom); bif.pi_rw_b = 1'($urandom);
    for (int i = 0; i < dly; i++) begin
      tick();
      chk("wait_state", state, 1);
      chk("wait_own", bif.bus_own, 0);
    end
    bif.bus_slot = 1'b1;
    tick();
    bif.bus_slot = 1'b0;
    chk("setup_state", state, 2);
    chk("setup_own", bif.bus_own, 1);
    chk("setup_addr", bif.bus_addr, a);
    chk("setup_doe", bif.bus_data_oe, !rd);
    if (!rd) chk("setup_dout", bif.bus_data_out, d);
    n = 0; oe_lo = 0; we_lo = 0;
    while (bif.pi_done !== 1'b1 && n < 12) begin
      if (bif.ram_oe_n === 1'b0) oe_lo++;
      if (bif.ram_we_n === 1'b0) we_lo++;
      if (!rd) chk("wr_doe_held", bif.bus_data_oe, 1);
      if (n == drop_at) bif.pi_pending = 1'b0;
      tick();
      n++;
    end
    chk("done_latency", n, S + T + 1);
    chk("done_state", state, 5);
    chk("done_err", bif.pi_error, 0);
    chk("done_own", bif.bus_own, 0);
    chk("done_doe", bif.bus_data_oe, 0);
    chk("oe_width", oe_lo, rd ? T : 0);
    chk("we_width", we_lo, rd ? 0 : T);
    if (rd) begin
      exp_rd = ref_read(a);
    end else begin
      ref_mem[a] = d;
      chk("ram_written", ram.exists(a) ? ram[a] : 8'hxx, d);
    end
    chk("rd_data", bif.pi_rd_data, exp_rd);
    if (bif.pi_pending) begin
      for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
        tick();
        chk("done_stay", state, 5);
        chk("done_level", bif.pi_done, 1);
      end
      bif.pi_pending = 1'b0;
    end
    tick();
    chk("back_idle", state, 0);
    chk("done_drop", bif.pi_done, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bif.pi_addr = '0; bif.pi_wr_data = '0; bif.pi_rw_b = 1'b0;
    bif.pi_pending = 1'b0; bif.bus_slot = 1'b0;
    exp_rd = 8'h00;

    // reset
    reset_n = 1'b0;
    tick(); tick();
    chk_reset("rst");
    reset_n = 1'b1;
    tick();
    chk("post_rst_state", state, 0);

    // directed read and write
    ram[17'h08000] = 8'hA5; ref_mem[17'h08000] = 8'hA5;
    do_txn(1'b1, 17'h08000, 8'h00, 2, -1, 1'b0);
    chk("dir_read_a5", bif.pi_rd_data, 8'hA5);
    do_txn(1'b0, 17'h1FFFF, 8'h3C, 1, -1, 1'b0);
    chk("dir_write_keeps_rd", bif.pi_rd_data, 8'hA5);

    // slot coinciding with pending rise in IDLE is ignored
    do_txn(1'b1, 17'h1FFFF, 8'h00, 0, -1, 1'b1);

    // abort in WAIT_SLOT, then a stray slot in IDLE
    bif.pi_addr = 17'h00123; bif.pi_rw_b = 1'b1; bif.pi_pending = 1'b1;
    tick(); tick();
    bif.pi_pending = 1'b0;
    tick();
    chk("abort_state", state, 0);
    chk_quiet("abort");
    chk("abort_done", bif.pi_done, 0);
    bif.bus_slot = 1'b1;
    tick();
    bif.bus_slot = 1'b0;
    chk("stray_slot_state", state, 0);
    chk("stray_slot_own", bif.bus_own, 0);

    // pending falls during the write strobe: strobe still full width
    do_txn(1'b0, 17'h04444, 8'h77, 0, 1, 1'b0);

    // reset in the middle of a write strobe
    bif.pi_addr = 17'h0ABCD; bif.pi_wr_data = 8'h99; bif.pi_rw_b = 1'b0; bif.pi_pending = 1'b1;
    tick();
    bif.bus_slot = 1'b1;
    tick();
    bif.bus_slot = 1'b0;
    tick();
    chk("mid_strobe_we", bif.ram_we_n, 0);
    reset_n = 1'b0;
    tick();
    exp_rd = 8'h00;
    chk_reset("rst_mid");
    reset_n = 1'b1; bif.pi_pending = 1'b0;
    tick();
    chk("rst_mid_idle", state, 0);

`ifdef PI_BUS_TIMEOUT_EN
    // no slot: timeout after TO cycles
    begin
      int n;
      bif.pi_addr = 17'h00321; bif.pi_rw_b = 1'b1; bif.pi_pending = 1'b1;
      tick();
      n = 0;
      while (bif.pi_done !== 1'b1 && n < 20) begin
        chk("to_no_oe", bif.ram_oe_n, 1);
        chk("to_no_own", bif.bus_own, 0);
        tick();
        n++;
      end
      chk("to_latency", n, TO);
      chk("to_err", bif.pi_error, 1);
      chk("to_rd_ff", bif.pi_rd_data, 8'hFF);
      chk_quiet("to");
      exp_rd = 8'hFF;
      bif.pi_pending = 1'b0;
      tick();
      chk("to_idle", state, 0);
      chk("to_err_clr", bif.pi_error, 0);
      chk("to_done_clr", bif.pi_done, 0);
    end
    // slot on the timeout cycle wins
    do_txn(1'b1, 17'h00321, 8'h00, TO - 1, -1, 1'b0);
`else
    // no timeout: WAIT_SLOT waits indefinitely
    bif.pi_pending = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("notimeout_state", state, 1);
    chk("notimeout_err", bif.pi_error, 0);
    chk("notimeout_done", bif.pi_done, 0);
    bif.pi_pending = 1'b0;
    tick();
    chk("notimeout_idle", state, 0);
`endif

    // randomized transactions over a small address pool
    for (int k = 0; k < 30; k++) begin
      bit          rd;
      logic [16:0] a;
      int          r;
      rd = 1'($urandom);
      a  = 17'($urandom_range(0, 7) * 17'h02345);
      r  = int'($urandom_range(0, 4));
      do_txn(rd, a, 8'($urandom), int'($urandom_range(0, 5)), (r == 4) ? -1 : r,
             1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
